// File: rtl/map_latch_gen.sv
// ============================================================================
// map_latch_gen
//
// Discrete-latch mapper core for single-register NES boards (Color Dreams,
// GxROM, CNROM-, UxROM- and AxROM-style). A CPU write to $8000-$FFFF captures
// one byte that is sliced into a PRG bank, a CHR bank and an optional
// one-screen mirroring select. All registers are also reachable through the
// save-state port.
//
// Compile-time option:
//   MAP_LATCH_BUS_CONFLICT_EN  - when defined, the latched value is
//                                cpu_dat & rom_dat (discrete-board bus
//                                conflict); otherwise rom_dat is ignored.
//
// Ports:
//   m2            in   CPU clock; registers update on its falling edge
//   map_rst       in   synchronous active-high reset (m2 falling edge)
//   cpu_addr[15:0] in  CPU address
//   cpu_dat[7:0]  in   CPU data bus (also save-state write data)
//   rom_dat[7:0]  in   PRG ROM output (bus-conflict input)
//   cpu_rw        in   1 = read
//   cpu_ce        in   active-low, low = $8000-$FFFF
//   ppu_addr[13:0] in  PPU address
//   ppu_oe/ppu_we in   active-low PPU strobes
//   cfg_chr_ram   in   board uses CHR RAM (no CHR banking, writable)
//   cfg_mir_v     in   hardwired vertical mirroring when no one-screen bit
//   ss_act/ss_we  in   save-state cycle / write
//   ss_addr[7:0]  in   save-state register index
//   prg_addr[21:0] out PRG memory address
//   chr_addr[18:0] out CHR memory address
//   ciram_a10     out  nametable select
//   ciram_ce      out  active-low CIRAM enable
//   rom_ce, prg_oe, chr_oe, chr_we  out  memory strobes
//   ss_rdat[7:0]  out  save-state readback
// ============================================================================
module map_latch_gen #(
    parameter int PRG_BITS    = 2,
    parameter int PRG_LSB     = 0,
    parameter int CHR_BITS    = 4,
    parameter int CHR_LSB     = 4,
    parameter int PRG_MODE    = 0,
    parameter int MIR_BIT     = 8,
    parameter int IGNORE_8000 = 0,
    parameter int MAP_IDX     = 11
) (
    input  logic        m2,
    input  logic        map_rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dat,
    input  logic [7:0]  rom_dat,
    input  logic        cpu_rw,
    input  logic        cpu_ce,
    input  logic [13:0] ppu_addr,
    input  logic        ppu_oe,
    input  logic        ppu_we,
    input  logic        cfg_chr_ram,
    input  logic        cfg_mir_v,
    input  logic        ss_act,
    input  logic        ss_we,
    input  logic [7:0]  ss_addr,
    output logic [21:0] prg_addr,
    output logic [18:0] chr_addr,
    output logic        ciram_a10,
    output logic        ciram_ce,
    output logic        rom_ce,
    output logic        prg_oe,
    output logic        chr_oe,
    output logic        chr_we,
    output logic [7:0]  ss_rdat
);

    // CHR register keeps one bit even when banking is disabled so the
    // save-state slot still has storage behind it.
    localparam int CHR_W = (CHR_BITS > 0) ? CHR_BITS : 1;

    logic [PRG_BITS-1:0] prg_bank;
    logic [CHR_W-1:0]    chr_bank;
    logic                mir_one;

    logic [7:0] wr_val;
    logic       drop;
    logic       cpu_wr;

`ifdef MAP_LATCH_BUS_CONFLICT_EN
    // Open-drain style fight between CPU and ROM: a 0 on either side wins.
    assign wr_val = cpu_dat & rom_dat;
`else
    logic unused_rom_dat;
    assign wr_val         = cpu_dat;
    assign unused_rom_dat = ^rom_dat;
`endif

    assign drop   = (IGNORE_8000 != 0) && (cpu_addr == 16'h8000);
    assign cpu_wr = !cpu_ce && !cpu_rw && !drop;

    // Save-state access outranks the CPU so a restore cannot be corrupted by
    // a concurrent bus write.
    always_ff @(negedge m2) begin
        if (map_rst) begin
            prg_bank <= '0;
            chr_bank <= '0;
            mir_one  <= 1'b0;
        end else if (ss_act) begin
            if (ss_we) begin
                case (ss_addr)
                    8'd0:    prg_bank <= cpu_dat[PRG_BITS-1:0];
                    8'd1:    chr_bank <= cpu_dat[CHR_W-1:0];
                    8'd2:    mir_one  <= cpu_dat[0];
                    default: ;
                endcase
            end
        end else if (cpu_wr) begin
            // Fields are extracted independently, so overlapping positions
            // simply share bits.
            prg_bank <= PRG_BITS'(wr_val >> PRG_LSB);
            if (CHR_BITS > 0) begin
                chr_bank <= CHR_W'(wr_val >> CHR_LSB);
            end
            if (MIR_BIT < 8) begin
                mir_one <= 1'(wr_val >> MIR_BIT);
            end
        end
    end

    always_comb begin
        prg_addr       = '0;
        prg_addr[13:0] = cpu_addr[13:0];
        if (PRG_MODE == 0) begin
            prg_addr[14]             = cpu_addr[14];
            prg_addr[15 +: PRG_BITS] = prg_bank;
        end else begin
            // $C000-$FFFF is pinned to the last bank of the chip.
            prg_addr[14 +: PRG_BITS] = cpu_addr[14] ? {PRG_BITS{1'b1}} : prg_bank;
        end
    end

    always_comb begin
        chr_addr       = '0;
        chr_addr[12:0] = ppu_addr[12:0];
        if ((CHR_BITS > 0) && !cfg_chr_ram) begin
            chr_addr[13 +: CHR_W] = chr_bank;
        end
    end

    always_comb begin
        if (MIR_BIT < 8) begin
            ciram_a10 = mir_one;
        end else begin
            ciram_a10 = cfg_mir_v ? ppu_addr[10] : ppu_addr[11];
        end
    end

    assign ciram_ce = !ppu_addr[13];
    assign rom_ce   = !cpu_ce;
    assign prg_oe   = cpu_rw;
    assign chr_oe   = !ppu_oe;
    assign chr_we   = cfg_chr_ram && !ppu_we && !ppu_addr[13];

    always_comb begin
        ss_rdat = 8'hFF;
        case (ss_addr)
            8'd0:    ss_rdat = 8'(prg_bank);
            8'd1:    ss_rdat = 8'(chr_bank);
            8'd2:    ss_rdat = {7'd0, mir_one};
            8'd127:  ss_rdat = 8'(MAP_IDX);
            default: ss_rdat = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_map_latch_gen.sv
module tb_map_latch_gen;

    logic        m2 = 1'b0;
    logic        map_rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dat, rom_dat;
    logic        cpu_rw, cpu_ce;
    logic [13:0] ppu_addr;
    logic        ppu_oe, ppu_we, cfg_chr_ram, cfg_mir_v;
    logic        ss_act, ss_we;
    logic [7:0]  ss_addr;

    logic [21:0] prg_addr0, prg_addr1;
    logic [18:0] chr_addr0, chr_addr1;
    logic        a10_0, a10_1, cce0, cce1;
    logic        rom_ce0, prg_oe0, chr_oe0, chr_we0;
    logic        rom_ce1, prg_oe1, chr_oe1, chr_we1;
    logic [7:0]  ss_rdat0, ss_rdat1;

    always #10 m2 = ~m2;

    // Instance 0: default parameters. Instance 1: 16 KB mode, $8000 quirk,
    // one-screen bit, narrow CHR field at an odd position.
    map_latch_gen u_dut0 (
        .m2(m2), .map_rst(map_rst), .cpu_addr(cpu_addr), .cpu_dat(cpu_dat),
        .rom_dat(rom_dat), .cpu_rw(cpu_rw), .cpu_ce(cpu_ce), .ppu_addr(ppu_addr),
        .ppu_oe(ppu_oe), .ppu_we(ppu_we), .cfg_chr_ram(cfg_chr_ram),
        .cfg_mir_v(cfg_mir_v), .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr),
        .prg_addr(prg_addr0), .chr_addr(chr_addr0), .ciram_a10(a10_0),
        .ciram_ce(cce0), .rom_ce(rom_ce0), .prg_oe(prg_oe0), .chr_oe(chr_oe0),
        .chr_we(chr_we0), .ss_rdat(ss_rdat0)
    );

    map_latch_gen #(
        .PRG_BITS(3), .PRG_LSB(0), .CHR_BITS(2), .CHR_LSB(5), .PRG_MODE(1),
        .MIR_BIT(4), .IGNORE_8000(1), .MAP_IDX(144)
    ) u_dut1 (
        .m2(m2), .map_rst(map_rst), .cpu_addr(cpu_addr), .cpu_dat(cpu_dat),
        .rom_dat(rom_dat), .cpu_rw(cpu_rw), .cpu_ce(cpu_ce), .ppu_addr(ppu_addr),
        .ppu_oe(ppu_oe), .ppu_we(ppu_we), .cfg_chr_ram(cfg_chr_ram),
        .cfg_mir_v(cfg_mir_v), .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr),
        .prg_addr(prg_addr1), .chr_addr(chr_addr1), .ciram_a10(a10_1),
        .ciram_ce(cce1), .rom_ce(rom_ce1), .prg_oe(prg_oe1), .chr_oe(chr_oe1),
        .chr_we(chr_we1), .ss_rdat(ss_rdat1)
    );

    // Reference model parameters, one entry per instance.
    int p_bits[2]  = '{2, 3};
    int p_lsb[2]   = '{0, 0};
    int c_bits[2]  = '{4, 2};
    int c_lsb[2]   = '{4, 5};
    int p_mode[2]  = '{0, 1};
    int m_bit[2]   = '{8, 4};
    int ign[2]     = '{0, 1};
    int map_idx[2] = '{11, 144};

    // Reference model state.
    int m_prg[2], m_chr[2], m_mir[2];

    typedef struct {
        logic [21:0] pa0, pa1;
        logic [18:0] ca0, ca1;
        logic        a0, a1;
        logic [7:0]  s0, s1;
        logic [4:0]  st;
    } exp_t;

    exp_t sb_q[$];
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic int exp_prg(input int i);
        int a = int'(cpu_addr);
        if (p_mode[i] == 0) return m_prg[i] * 32768 + (a % 32768);
        return ((a / 16384) % 2 == 1 ? (1 << p_bits[i]) - 1 : m_prg[i]) * 16384 + (a % 16384);
    endfunction

    function automatic int exp_chr(input int i);
        int base = (cfg_chr_ram || c_bits[i] == 0) ? 0 : m_chr[i] * 8192;
        return base + (int'(ppu_addr) % 8192);
    endfunction

    function automatic int exp_a10(input int i);
        int pa = int'(ppu_addr);
        if (m_bit[i] < 8) return m_mir[i];
        return cfg_mir_v ? (pa / 1024) % 2 : (pa / 2048) % 2;
    endfunction

    function automatic int exp_ss(input int i);
        case (int'(ss_addr))
            0:       return m_prg[i];
            1:       return m_chr[i];
            2:       return m_mir[i];
            127:     return map_idx[i];
            default: return 255;
        endcase
    endfunction

    function automatic int wval();
`ifdef MAP_LATCH_BUS_CONFLICT_EN
        return int'(cpu_dat & rom_dat);
`else
        return int'(cpu_dat);
`endif
    endfunction

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            if (map_rst) begin
                m_prg[i] = 0; m_chr[i] = 0; m_mir[i] = 0;
            end else if (ss_act) begin
                if (ss_we) begin
                    if (ss_addr == 8'd0) m_prg[i] = int'(cpu_dat) % (1 << p_bits[i]);
                    if (ss_addr == 8'd1) m_chr[i] = int'(cpu_dat) % (1 << (c_bits[i] > 0 ? c_bits[i] : 1));
                    if (ss_addr == 8'd2) m_mir[i] = int'(cpu_dat) % 2;
                end
            end else if (!cpu_ce && !cpu_rw && !(ign[i] == 1 && cpu_addr == 16'h8000)) begin
                int v = wval();
                m_prg[i] = (v >> p_lsb[i]) % (1 << p_bits[i]);
                if (c_bits[i] > 0) m_chr[i] = (v >> c_lsb[i]) % (1 << c_bits[i]);
                if (m_bit[i] < 8) m_mir[i] = (v >> m_bit[i]) % 2;
            end
        end
    endtask

    // Called just after a falling edge with inputs already driven: queue what
    // the outputs must show during this cycle, then advance the model across
    // the next falling edge.
    task automatic step();
        exp_t e;
        e.pa0 = 22'(exp_prg(0));  e.pa1 = 22'(exp_prg(1));
        e.ca0 = 19'(exp_chr(0));  e.ca1 = 19'(exp_chr(1));
        e.a0  = 1'(exp_a10(0));   e.a1  = 1'(exp_a10(1));
        e.s0  = 8'(exp_ss(0));    e.s1  = 8'(exp_ss(1));
        e.st  = {!cpu_ce, cpu_rw, !ppu_oe,
                 cfg_chr_ram && !ppu_we && (int'(ppu_addr) < 8192),
                 int'(ppu_addr) < 8192};
        sb_q.push_back(e);
        model_update();
        @(negedge m2);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_dat = d; cpu_rw = 1'b0; cpu_ce = 1'b0;
        step();
        cpu_rw = 1'b1;
    endtask

    task automatic cpu_read(input logic [15:0] a, input logic [13:0] pa);
        cpu_addr = a; cpu_rw = 1'b1; cpu_ce = !a[15]; ppu_addr = pa; ppu_oe = 1'b0;
        step();
        ppu_oe = 1'b1;
    endtask

    // Monitor: outputs are sampled mid-cycle on the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge m2);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("prg_addr0", 32'(prg_addr0), 32'(e.pa0));
                chk("prg_addr1", 32'(prg_addr1), 32'(e.pa1));
                chk("chr_addr0", 32'(chr_addr0), 32'(e.ca0));
                chk("chr_addr1", 32'(chr_addr1), 32'(e.ca1));
                chk("ciram_a10_0", 32'(a10_0), 32'(e.a0));
                chk("ciram_a10_1", 32'(a10_1), 32'(e.a1));
                chk("ss_rdat0", 32'(ss_rdat0), 32'(e.s0));
                chk("ss_rdat1", 32'(ss_rdat1), 32'(e.s1));
                chk("strobes0", 32'({rom_ce0, prg_oe0, chr_oe0, chr_we0, cce0}), 32'(e.st));
                chk("strobes1", 32'({rom_ce1, prg_oe1, chr_oe1, chr_we1, cce1}), 32'(e.st));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        map_rst = 1'b1; cpu_addr = 16'h0000; cpu_dat = 8'h00; rom_dat = 8'hFF;
        cpu_rw = 1'b1; cpu_ce = 1'b1; ppu_addr = 14'h0000; ppu_oe = 1'b1;
        ppu_we = 1'b1; cfg_chr_ram = 1'b0; cfg_mir_v = 1'b0;
        ss_act = 1'b0; ss_we = 1'b0; ss_addr = 8'd0;
        for (int i = 0; i < 2; i++) begin m_prg[i] = 0; m_chr[i] = 0; m_mir[i] = 0; end
        @(negedge m2);
        #1;

        // Reset state, including readbacks and the fixed $C000 window.
        step();
        ss_addr = 8'd1; cpu_addr = 16'hC000; step();
        ss_addr = 8'd2; step();
        map_rst = 1'b0;
        ss_addr = 8'd127; step();

        // Default slicing.
        ss_addr = 8'd0;
        cpu_write(16'h8123, 8'hA3);
        cpu_read(16'h8000, 14'h0456);
        // 16 KB mode on instance 1.
        cpu_write(16'h8001, 8'h02);
        cpu_read(16'h8001, 14'h0000);
        cpu_read(16'hC001, 14'h0000);
        // $8000 quirk.
        cpu_write(16'h8000, 8'hFF);
        cpu_read(16'hC123, 14'h0100);
        cpu_write(16'h8001, 8'h11);
        cpu_read(16'h8456, 14'h1FFF);
        // One-screen select.
        cpu_write(16'h9000, 8'h10);
        cpu_read(16'h8000, 14'h2000);
        cpu_read(16'h8000, 14'h2C00);
        cpu_write(16'h9000, 8'h00);
        cpu_read(16'h8000, 14'h2000);
        // Bus conflict.
        rom_dat = 8'h0F;
        cpu_write(16'hF000, 8'hF3);
        ss_addr = 8'd1;
        cpu_read(16'hF000, 14'h0456);
        rom_dat = 8'hFF;
        // RMW double write: last one wins.
        cpu_write(16'h8005, 8'h21);
        cpu_write(16'h8005, 8'h42);
        cpu_read(16'h8005, 14'h0000);

        // Save state.
        ss_act = 1'b1; ss_we = 1'b1; ss_addr = 8'd1; cpu_dat = 8'h05; step();
        ss_we = 1'b0; step();
        ss_addr = 8'd127; step();
        ss_we = 1'b1; ss_addr = 8'd2; cpu_dat = 8'h01; step();
        ss_we = 1'b0; step();
        // Save-state write blocks a simultaneous CPU write.
        ss_we = 1'b1; ss_addr = 8'd0; cpu_dat = 8'h03; cpu_ce = 1'b0; cpu_rw = 1'b0;
        cpu_addr = 16'h8001; step();
        cpu_ce = 1'b1; cpu_rw = 1'b1; ss_we = 1'b0; step();
        // Reset wins over a save-state write.
        map_rst = 1'b1; ss_we = 1'b1; ss_addr = 8'd1; cpu_dat = 8'h07; step();
        map_rst = 1'b0; ss_we = 1'b0; ss_act = 1'b0;
        for (int k = 0; k < 3; k++) begin ss_addr = 8'(k); step(); end

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            map_rst     = ($urandom_range(0, 40) == 0);
            ss_act      = ($urandom_range(0, 7) == 0);
            ss_we       = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 4))
                0: ss_addr = 8'd0;
                1: ss_addr = 8'd1;
                2: ss_addr = 8'd2;
                3: ss_addr = 8'd127;
                default: ss_addr = 8'($urandom);
            endcase
            cpu_ce      = $urandom_range(0, 1) == 1;
            cpu_rw      = $urandom_range(0, 1) == 1;
            cpu_addr    = ($urandom_range(0, 5) == 0) ? 16'h8000 : 16'($urandom);
            cpu_dat     = 8'($urandom);
            rom_dat     = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
            ppu_addr    = 14'($urandom);
            ppu_oe      = $urandom_range(0, 1) == 1;
            ppu_we      = $urandom_range(0, 1) == 1;
            cfg_chr_ram = ($urandom_range(0, 3) == 0);
            cfg_mir_v   = $urandom_range(0, 1) == 1;
            step();
        end

        for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(posedge m2);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/map_latch_gen.md
# map_latch_gen

Parametrised discrete-latch mapper core for single-register NES boards (Color Dreams, GxROM, CNROM-, UxROM- and AxROM-style). It sits between the CPU/PPU bus decode and the PRG/CHR memory address outputs. A write to $8000-$FFFF captures one byte, which is sliced into PRG bank, CHR bank and an optional one-screen mirroring bit. The block adds optional bus-conflict emulation, a 16 KB switch/fixed-last PRG mode and save-state access to every register.

## Interface
Parameters:
- PRG_BITS, 2, PRG bank field width (1-6)
- PRG_LSB, 0, bit position of PRG field in written byte
- CHR_BITS, 4, CHR bank field width (0-6; 0 = no CHR banking)
- CHR_LSB, 4, bit position of CHR field
- PRG_MODE, 0, 0 = 32 KB switchable; 1 = 16 KB switchable at $8000, last bank fixed at $C000
- MIR_BIT, 8, bit index of one-screen select; 8 = disabled
- IGNORE_8000, 0, 1 = writes to exactly $8000 are dropped (mapper 144 quirk)
- MAP_IDX, 11, mapper number returned at save-state address 127

Ports:
- m2  in  1  CPU clock; all registers update on its falling edge
- map_rst  in  1  synchronous active-high reset, sampled on the m2 falling edge
- cpu_addr  in  16  CPU address
- cpu_dat  in  8  CPU data bus
- rom_dat  in  8  PRG ROM output at the current address (bus-conflict input)
- cpu_rw  in  1  1 = read
- cpu_ce  in  1  active-low; low = $8000-$FFFF
- ppu_addr  in  14  PPU address
- ppu_oe, ppu_we  in  1  active-low PPU strobes
- cfg_chr_ram, cfg_mir_v  in  1  system config
- ss_act, ss_we  in  1  save-state cycle / write
- ss_addr  in  8  save-state register index
- prg_addr  out  22  PRG address
- chr_addr  out  19  CHR address
- ciram_a10, ciram_ce  out  1  nametable select / active-low CIRAM enable
- rom_ce, prg_oe, chr_oe, chr_we  out  1  memory strobes
- ss_rdat  out  8  save-state readback

## Operation
- Registers: prg_bank[PRG_BITS-1:0], chr_bank[max(CHR_BITS,1)-1:0], mir_one.
- Priority per m2 falling edge: map_rst, then ss_act, then CPU write.
  - map_rst: all registers clear to 0.
  - ss_act & ss_we: address 0 loads prg_bank, 1 loads chr_bank, 2 loads mir_one (bit 0), each from cpu_dat LSBs.
  - CPU write (!cpu_ce & !cpu_rw & !drop): value v is sliced into the fields. drop = IGNORE_8000 & cpu_addr==16'h8000.
- prg_addr[13:0] = cpu_addr[13:0].
  - PRG_MODE 0: prg_addr[14] = cpu_addr[14] and bits [15+:PRG_BITS] = prg_bank.
  - PRG_MODE 1: window bank = cpu_addr[14] ? all-ones : prg_bank, placed at [14+:PRG_BITS].
  - Upper bits are 0.
- chr_addr[12:0] = ppu_addr[12:0]; bits above carry chr_bank, or 0 when cfg_chr_ram or CHR_BITS==0.
- Mirroring:
  - MIR_BIT<8: ciram_a10 = mir_one.
  - Otherwise: cfg_mir_v ? ppu_addr[10] : ppu_addr[11].
  - ciram_ce = !ppu_addr[13].
- Strobes:
  - rom_ce = !cpu_ce
  - prg_oe = cpu_rw
  - chr_oe = !ppu_oe
  - chr_we = cfg_chr_ram & !ppu_we & ppu_addr[13]==0
- ss_rdat:
  - addr 0 → prg_bank, zero-extended
  - 1 → chr_bank
  - 2 → {7'd0,mir_one}
  - 127 → MAP_IDX
  - else 8'hFF

## Timing
- Reset values: all bank registers 0, so prg_addr[14+] = 0 in mode 0. In mode 1, the $C000 window reads the all-ones bank. mir_one = 0.
- Write latency: the register changes on the m2 falling edge that ends the write cycle. The new mapping is visible from the next CPU cycle; outputs are combinational from the registers.
- RMW double writes: both writes are captured; the last one wins.
- Reset asserted during a save-state cycle: reset wins and ss_we is ignored.
- Field overlap (for example MIR_BIT inside the CHR field): each field takes its own bits; no error.

## Configuration
- MAP_LATCH_BUS_CONFLICT_EN defined: v = cpu_dat & rom_dat, emulating discrete-board bus conflicts.
- Undefined: v = cpu_dat, and rom_dat is unused.

## Test plan
- Defaults, write 8'hA3 to $8123 → prg_bank=3, chr_bank=10; $8000 fetch → prg_addr=22'h018000; PPU $0456 read → chr_addr=19'h14456.
- PRG_MODE=1, PRG_BITS=3, write 8'h02 → CPU $8001 → prg_addr=22'h008001; CPU $C001 → prg_addr=22'h01C001.
- IGNORE_8000=1: write 8'hFF to $8000 → registers unchanged; write 8'h11 to $8001 → prg_bank=1, chr_bank=1.
- MIR_BIT=4: write 8'h10 → ciram_a10=1 for PPU $2000 and $2C00; write 8'h00 → ciram_a10=0.
- Bus conflict on, rom_dat=8'h0F, cpu_dat=8'hF3 → prg_bank=3, chr_bank=0; macro off → chr_bank=15.
- Save state: ss_we with ss_addr=1, data 8'h05 → ss_rdat=8'h05 at addr 1; ss_addr 127 → MAP_IDX; then map_rst → all readbacks 0.
